wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final pipeline stage. Consumes the registered bundle produced by the memory stage.
- Aligns and extends load data from the data SRAM and selects the writeback value. Drives the register-file write port, forwarding outputs and debug trace.
- Commits exceptions and ertn to the CSR unit and raises the pipeline flush.
- Maintains a retired-instruction counter. Holds commit while the trace sink stalls, with no loss of the one-cycle-valid SRAM read data.

Parameters:
PC_RESET  32'h1c000000  reset value of debug_wb_pc
INSTRET_W  64  retired-instruction counter width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
in_valid  in  1  memory-stage bundle valid
in_ready  out  1  stage can accept/retire this cycle
trace_stall  in  1  trace sink busy; blocks commit
pc  in  32  instruction PC
mem_op  in  8  [0]LB [1]LH [2]LW [3]LBU [4]LHU [5]SB [6]SH [7]SW
result  in  32  ALU/mul/div result
result_bypass  in  32  raw ALU result (load address)
res_from_mem  in  1  writeback from load data
res_from_csr  in  1  writeback from csr_rvalue
gr_we  in  1  register write enable
dest  in  5  destination register
data_sram_rdata  in  32  SRAM read data, valid only in the first cycle in_valid is high for an instruction
csr_rvalue  in  32  CSR read value
has_exception  in  1  instruction carries exception
ecode  in  6  exception code
esubcode  in  9  exception subcode
exception_maddr  in  32  faulting address
ertn  in  1  instruction is ertn
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
fwd_valid  out  1  forwarding entry valid
fwd_dest  out  5  forwarding destination
fwd_value  out  32  forwarding value
this_exception  out  1  to memory stage: suppress younger stores
ex_flush  out  1  pipeline flush (exception or ertn)
wb_ex  out  1  exception commit to CSR
wb_ecode  out  6  to CSR
wb_esubcode  out  9  to CSR
wb_pc  out  32  to CSR (ERA)
wb_vaddr  out  32  to CSR (BADV)
ertn_flush  out  1  ertn commit to CSR
instret  out  INSTRET_W  retired-instruction count
debug_wb_pc  out  32  trace PC
debug_wb_rf_we  out  4  trace write-enable byte mask
debug_wb_rf_wnum  out  5  trace write register
debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- commit = in_valid & ~trace_stall.
- in_ready = resetn & (~in_valid | commit).
- held: register. Reset 0. Next value = in_valid & ~commit.
- rdata_buf: 32-bit register. Captures data_sram_rdata when in_valid & ~held & ~commit. Reset 0.
- load_raw = held ? rdata_buf : data_sram_rdata. Read data is therefore correct for any stall length.
- Byte select: result_bypass[1:0]. Halfword select: result_bypass[1].
  - LB/LBU: sign/zero-extend the selected byte.
  - LH/LHU: sign/zero-extend the selected half.
  - LW: word as-is.
  - Misalignment is an upstream exception; no check here.
- final_value priority: res_from_mem → load data; else res_from_csr → csr_rvalue; else result.
- Register-file write:
  - rf_we = commit & gr_we & ~has_exception & (dest != 0).
  - rf_waddr = dest; rf_wdata = final_value.
  - Exactly one write per instruction, even under stall.
- Forwarding:
  - fwd_valid = in_valid & gr_we & ~has_exception & (dest != 0).
  - Asserted during stall as well.
  - fwd_dest = dest; fwd_value = final_value.
- this_exception = in_valid & (has_exception | ertn). Independent of stall.
- CSR commit:
  - wb_ex = commit & has_exception.
  - ertn_flush = commit & ertn & ~has_exception.
  - ex_flush = wb_ex | ertn_flush. Single-cycle pulses, combinational in the commit cycle.
  - wb_ecode / wb_esubcode / wb_vaddr / wb_pc pass through.
- instret: +1 on commit & ~has_exception, including ertn. Wraps modulo 2^INSTRET_W. Reset 0.
- Debug trace:
  - debug_wb_pc: registered. Loads pc on commit. Reset PC_RESET.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum / debug_wb_rf_wdata mirror rf_waddr / rf_wdata.
- Reset mid-stall clears held and rdata_buf. No commit occurs during reset.
- Reset values of combinational outputs follow from in_valid=0 (upstream valid is 0 during reset): all enables and pulses 0.

Decomposition:
- Shared package: mem_op bit-index constants, ecode constants, PC_RESET.
- One natural sub-module: wb_load_align (combinational).
  - Inputs: mem_op[4:0], addr[1:0], raw word.
  - Output: extended 32-bit value.

Test Plan:
- LB, addr low bits 2'b11, rdata 32'h80FF_1234, no stall → rf_we=1, rf_wdata 32'hFFFF_FF80; LBU → 32'h0000_0080.
- LH, addr low bits 2'b10, rdata 32'h8001_7FFF, trace_stall high 3 cycles with rdata changed to 32'h0 after the first cycle → single rf_we on release, data 32'hFFFF_8001, in_ready low for those 3 cycles.
- has_exception=1, ecode 6'h0B, pc 32'h1c00_0040, gr_we=1 → this_exception=1, wb_ex=ex_flush=1 for one cycle, rf_we=0, instret unchanged.
- ertn committed → ertn_flush=1, ex_flush=1, instret +1, no register write.
- res_from_csr with csr_rvalue 32'hDEAD_BEEF, dest=5'd4 → rf_wdata 32'hDEAD_BEEF; same instruction with dest=0 → rf_we=0, fwd_valid=0.
- resetn low during a stall → held and rdata_buf cleared, instret=0, debug_wb_pc=32'h1c00_0000.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// =============================================================================
// Module : wb_stage_pkg
// Brief  : Shared constants for the writeback stage (mem_op bits, ecodes, PC reset).
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package wb_stage_pkg;

  // mem_op one-hot bit positions
  localparam int C_OP_LB  = 0;
  localparam int C_OP_LH  = 1;
  localparam int C_OP_LW  = 2;
  localparam int C_OP_LBU = 3;
  localparam int C_OP_LHU = 4;
  localparam int C_OP_SB  = 5;
  localparam int C_OP_SH  = 6;
  localparam int C_OP_SW  = 7;

  localparam logic [5:0] C_ECODE_INT = 6'h00;
  localparam logic [5:0] C_ECODE_ADE = 6'h08;
  localparam logic [5:0] C_ECODE_ALE = 6'h09;
  localparam logic [5:0] C_ECODE_SYS = 6'h0B;
  localparam logic [5:0] C_ECODE_BRK = 6'h0C;
  localparam logic [5:0] C_ECODE_INE = 6'h0D;

  localparam logic [31:0] C_PC_RESET = 32'h1c00_0000;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// =============================================================================
// Module : wb_load_align
// Brief  : Selects and sign/zero-extends load data from the raw SRAM word.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [4:0]  mem_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] raw_i,
  output logic [31:0] value_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_i)
      2'b00:   w_byte = raw_i[7:0];
      2'b01:   w_byte = raw_i[15:8];
      2'b10:   w_byte = raw_i[23:16];
      default: w_byte = raw_i[31:24];
    endcase
    w_half = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  // Non-load ops fall through to the full word; it is never selected for them.
  always_comb begin
    value_o = raw_i;
    if (mem_op_i[C_OP_LB])       value_o = ext8(w_byte, 1'b1);
    else if (mem_op_i[C_OP_LBU]) value_o = ext8(w_byte, 1'b0);
    else if (mem_op_i[C_OP_LH])  value_o = ext16(w_half, 1'b1);
    else if (mem_op_i[C_OP_LHU]) value_o = ext16(w_half, 1'b0);
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// =============================================================================
// Module : wb_stage
// Brief  : Pipeline writeback stage: load align, RF write, CSR commit, trace.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = C_PC_RESET,
  parameter int          INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 trace_stall,
  input  logic [31:0]          pc,
  input  logic [7:0]           mem_op,
  input  logic [31:0]          result,
  input  logic [31:0]          result_bypass,
  input  logic                 res_from_mem,
  input  logic                 res_from_csr,
  input  logic                 gr_we,
  input  logic [4:0]           dest,
  input  logic [31:0]          data_sram_rdata,
  input  logic [31:0]          csr_rvalue,
  input  logic                 has_exception,
  input  logic [5:0]           ecode,
  input  logic [8:0]           esubcode,
  input  logic [31:0]          exception_maddr,
  input  logic                 ertn,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_dest,
  output logic [31:0]          fwd_value,
  output logic                 this_exception,
  output logic                 ex_flush,
  output logic                 wb_ex,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [31:0]          wb_pc,
  output logic [31:0]          wb_vaddr,
  output logic                 ertn_flush,
  output logic [INSTRET_W-1:0] instret,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  logic                 held_q, held_d;
  logic [31:0]          rdata_buf_q, rdata_buf_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [31:0]          pc_q, pc_d;

  logic        w_commit;
  logic [31:0] w_load_raw;
  logic [31:0] w_load_val;
  logic [31:0] w_final;
  logic        w_wr_ok;
  logic        w_unused;

  // Resetn gating keeps a stray in_valid during reset from committing.
  assign w_commit   = resetn & in_valid & ~trace_stall;
  assign in_ready   = resetn & (~in_valid | w_commit);
  // SRAM data is only valid on the first cycle; later stall cycles use the copy.
  assign w_load_raw = held_q ? rdata_buf_q : data_sram_rdata;

  wb_load_align u_align (
    .mem_op_i (mem_op[4:0]),
    .addr_i   (result_bypass[1:0]),
    .raw_i    (w_load_raw),
    .value_o  (w_load_val)
  );

  always_comb begin
    w_final = result;
    if (res_from_mem)      w_final = w_load_val;
    else if (res_from_csr) w_final = csr_rvalue;
  end

  assign w_wr_ok   = gr_we & ~has_exception & (dest != 5'd0);
  assign rf_we     = w_commit & w_wr_ok;
  assign rf_waddr  = dest;
  assign rf_wdata  = w_final;

  assign fwd_valid = in_valid & w_wr_ok;
  assign fwd_dest  = dest;
  assign fwd_value = w_final;

  assign this_exception = in_valid & (has_exception | ertn);
  assign wb_ex          = w_commit & has_exception;
  assign ertn_flush     = w_commit & ertn & ~has_exception;
  assign ex_flush       = wb_ex | ertn_flush;
  assign wb_ecode       = ecode;
  assign wb_esubcode    = esubcode;
  assign wb_pc          = pc;
  assign wb_vaddr       = exception_maddr;

  assign instret           = instret_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_comb begin
    held_d      = in_valid & ~w_commit;
    rdata_buf_d = rdata_buf_q;
    if (in_valid && !held_q && !w_commit) rdata_buf_d = data_sram_rdata;
    instret_d = instret_q;
    if (w_commit && !has_exception) instret_d = instret_q + 1'b1;
    pc_d = pc_q;
    if (w_commit) pc_d = pc;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      held_q      <= 1'b0;
      rdata_buf_q <= 32'h0;
      instret_q   <= '0;
      pc_q        <= PC_RESET;
    end else begin
      held_q      <= held_d;
      rdata_buf_q <= rdata_buf_d;
      instret_q   <= instret_d;
      pc_q        <= pc_d;
    end
  end

  assign w_unused = ^{mem_op[7:5], result_bypass[31:2]};

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// =============================================================================
// Module : tb_wb_stage
// Brief  : Directed self-checking bench for wb_stage.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, trace_stall;
  logic [31:0] pc;
  logic [7:0]  mem_op;
  logic [31:0] result, result_bypass;
  logic        res_from_mem, res_from_csr, gr_we;
  logic [4:0]  dest;
  logic [31:0] data_sram_rdata, csr_rvalue;
  logic        has_exception;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] exception_maddr;
  logic        ertn;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_value;
  logic        this_exception, ex_flush, wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush;
  logic [63:0] instret;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_instret;

  always #5 clk = ~clk;

  wb_stage #(.PC_RESET(32'h1c00_0000), .INSTRET_W(64)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .trace_stall(trace_stall), .pc(pc), .mem_op(mem_op), .result(result),
    .result_bypass(result_bypass), .res_from_mem(res_from_mem),
    .res_from_csr(res_from_csr), .gr_we(gr_we), .dest(dest),
    .data_sram_rdata(data_sram_rdata), .csr_rvalue(csr_rvalue),
    .has_exception(has_exception), .ecode(ecode), .esubcode(esubcode),
    .exception_maddr(exception_maddr), .ertn(ertn), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .fwd_dest(fwd_dest), .fwd_value(fwd_value), .this_exception(this_exception),
    .ex_flush(ex_flush), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .ertn_flush(ertn_flush), .instret(instret), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; trace_stall = 0; pc = 32'h0; mem_op = 8'h0;
    result = 32'h0; result_bypass = 32'h0; res_from_mem = 0; res_from_csr = 0;
    gr_we = 0; dest = 5'd0; data_sram_rdata = 32'h0; csr_rvalue = 32'h0;
    has_exception = 0; ecode = 6'h0; esubcode = 9'h0; exception_maddr = 32'h0;
    ertn = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a_pc, input logic [7:0] op,
                      input logic [31:0] addr, input logic [31:0] rd, input logic [4:0] d);
    idle();
    in_valid = 1; pc = a_pc; mem_op = op; result_bypass = addr;
    data_sram_rdata = rd; res_from_mem = 1; gr_we = 1; dest = d;
  endtask

  initial begin
    idle();
    resetn = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_instret", instret, 64'h0);
    chk("rst_dbg_pc", 64'(debug_wb_pc), 64'(32'h1c00_0000));
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_ex_flush", 64'(ex_flush), 64'(0));
    tick();
    resetn = 1;
    exp_instret = 0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // LB byte 3, no stall
    tick();
    load(32'h1c00_0010, 8'b0000_0001, 32'h0000_1003, 32'h80FF_1234, 5'd7);
    @(negedge clk);
    chk("lb_rf_we", 64'(rf_we), 64'(1));
    chk("lb_wdata", 64'(rf_wdata), 64'(32'hFFFF_FF80));
    chk("lb_waddr", 64'(rf_waddr), 64'(7));
    chk("lb_dbg_we", 64'(debug_wb_rf_we), 64'(4'hF));
    chk("lb_fwd", 64'({fwd_valid, fwd_dest}), 64'({1'b1, 5'd7}));
    tick();
    exp_instret++;
    chk("lb_instret", instret, exp_instret);
    chk("lb_dbg_pc", 64'(debug_wb_pc), 64'(32'h1c00_0010));

    // LBU same byte
    load(32'h1c00_0014, 8'b0000_1000, 32'h0000_1003, 32'h80FF_1234, 5'd8);
    @(negedge clk);
    chk("lbu_wdata", 64'(rf_wdata), 64'(32'h0000_0080));
    tick();
    exp_instret++;

    // LHU low half
    load(32'h1c00_0018, 8'b0001_0000, 32'h0000_2000, 32'h8001_F00D, 5'd9);
    @(negedge clk);
    chk("lhu_wdata", 64'(rf_wdata), 64'(32'h0000_F00D));
    tick();
    exp_instret++;

    // LH upper half, trace stall 3 cycles, SRAM data gone after first
    load(32'h1c00_0020, 8'b0000_0010, 32'h0000_2002, 32'h8001_7FFF, 5'd10);
    trace_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lh_stall_ready", 64'(in_ready), 64'(0));
      chk("lh_stall_rf_we", 64'(rf_we), 64'(0));
      chk("lh_stall_fwd", 64'({fwd_valid, fwd_value}), 64'({1'b1, 32'hFFFF_8001}));
      tick();
      data_sram_rdata = 32'h0;
    end
    chk("lh_stall_instret", instret, exp_instret);
    trace_stall = 0;
    @(negedge clk);
    chk("lh_rel_rf_we", 64'(rf_we), 64'(1));
    chk("lh_rel_wdata", 64'(rf_wdata), 64'(32'hFFFF_8001));
    chk("lh_rel_ready", 64'(in_ready), 64'(1));
    tick();
    exp_instret++;
    idle();
    @(negedge clk);
    chk("lh_after_rf_we", 64'(rf_we), 64'(0));
    chk("lh_instret", instret, exp_instret);

    // Exception, first held by stall then committed
    tick();
    idle();
    in_valid = 1; has_exception = 1; ecode = 6'h0B; esubcode = 9'h0;
    pc = 32'h1c00_0040; gr_we = 1; dest = 5'd3; exception_maddr = 32'h0000_1234;
    trace_stall = 1;
    @(negedge clk);
    chk("exs_this_exc", 64'(this_exception), 64'(1));
    chk("exs_wb_ex", 64'(wb_ex), 64'(0));
    tick();
    trace_stall = 0;
    @(negedge clk);
    chk("ex_this_exc", 64'(this_exception), 64'(1));
    chk("ex_flags", 64'({wb_ex, ex_flush, ertn_flush}), 64'(3'b110));
    chk("ex_rf_we", 64'(rf_we), 64'(0));
    chk("ex_fwd", 64'(fwd_valid), 64'(0));
    chk("ex_csr", 64'({wb_ecode, wb_esubcode, wb_pc, wb_vaddr}),
        64'({6'h0B, 9'h0, 32'h1c00_0040, 32'h0000_1234}));
    tick();
    idle();
    @(negedge clk);
    chk("ex_pulse_end", 64'({wb_ex, ex_flush}), 64'(0));
    chk("ex_instret", instret, exp_instret);
    chk("ex_dbg_pc", 64'(debug_wb_pc), 64'(32'h1c00_0040));

    // ertn
    tick();
    idle();
    in_valid = 1; ertn = 1; pc = 32'h1c00_0044;
    @(negedge clk);
    chk("ertn_flags", 64'({wb_ex, ex_flush, ertn_flush}), 64'(3'b011));
    chk("ertn_this_exc", 64'(this_exception), 64'(1));
    chk("ertn_rf_we", 64'(rf_we), 64'(0));
    tick();
    exp_instret++;
    idle();
    @(negedge clk);
    chk("ertn_instret", instret, exp_instret);

    // CSR read writeback, then dest = 0
    tick();
    idle();
    in_valid = 1; res_from_csr = 1; csr_rvalue = 32'hDEAD_BEEF; result = 32'h1111_1111;
    gr_we = 1; dest = 5'd4; pc = 32'h1c00_0048;
    @(negedge clk);
    chk("csr_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
    chk("csr_rf_we", 64'(rf_we), 64'(1));
    tick();
    exp_instret++;
    dest = 5'd0;
    @(negedge clk);
    chk("csr_d0_rf_we", 64'(rf_we), 64'(0));
    chk("csr_d0_fwd", 64'(fwd_valid), 64'(0));
    chk("csr_d0_dbg_we", 64'(debug_wb_rf_we), 64'(0));
    tick();
    exp_instret++;

    // Plain ALU result
    res_from_csr = 0; dest = 5'd12; result = 32'h1234_5678;
    @(negedge clk);
    chk("alu_wdata", 64'(rf_wdata), 64'(32'h1234_5678));
    tick();
    exp_instret++;
    idle();
    @(negedge clk);
    chk("alu_instret", instret, exp_instret);

    // Reset in the middle of a stalled load
    tick();
    load(32'h1c00_0060, 8'b0000_0100, 32'h0000_3000, 32'hAAAA_5555, 5'd13);
    trace_stall = 1;
    tick();
    data_sram_rdata = 32'h0;
    resetn = 0;
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'(0));
    chk("mrst_rf_we", 64'(rf_we), 64'(0));
    tick();
    @(negedge clk);
    chk("mrst_instret", instret, 64'h0);
    chk("mrst_dbg_pc", 64'(debug_wb_pc), 64'(32'h1c00_0000));
    tick();
    resetn = 1;
    load(32'h1c00_0070, 8'b0000_0100, 32'h0000_3000, 32'h0BAD_F00D, 5'd14);
    @(negedge clk);
    chk("mrst_fresh_data", 64'(rf_wdata), 64'(32'h0BAD_F00D));
    chk("mrst_fresh_we", 64'(rf_we), 64'(1));
    tick();
    idle();
    @(negedge clk);
    chk("mrst_post_instret", instret, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
